// File: rtl/line_fifo_sync_param.sv
// line_fifo_sync_param
//   Single-clock line-buffer FIFO for the binarise/erode/dilate pipeline, one instance per
//   buffered image line ahead of the 3x3 morphology window. It holds DEPTH = 2**ADDR_WIDTH
//   words of DATA_WIDTH bits. It provides:
//   - runtime almost-full/almost-empty thresholds
//   - occupancy (water level) reporting
//   - overflow/underflow pulses
//   - synchronous flush
//
// Build option
//   LINE_FIFO_FWFT_EN  When defined, the read port is first-word fall-through.
//                      When undefined (the default), rd_data is registered and arrives one
//                      cycle after an accepted pop.
//
// Ports
//   clk, tb_rst               clock (rising edge); asynchronous active-high reset
//   flush                     synchronous clear of pointers and level (RAM untouched)
//   af_thresh, ae_thresh      thresholds, captured when thresh_ld=1 (saturated to DEPTH)
//   thresh_ld                 threshold load strobe
//   wr_en, wr_data            write request and word
//   wr_full, almost_full      level == DEPTH, level >= af threshold
//   overflow                  1-cycle pulse after a write rejected because full
//   rd_en                     pop request
//   rd_data, rd_valid         read word and its valid strobe
//   rd_empty, almost_empty    level == 0, level <= ae threshold
//   underflow                 1-cycle pulse after a pop rejected because empty
//   water_level               occupancy 0..DEPTH
module line_fifo_sync_param #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned AF_DEFAULT = 1020,
    parameter int unsigned AE_DEFAULT = 4
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  flush,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    input  logic                  thresh_ld,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   water_level
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t DepthP = ptr_t'(DEPTH);
    localparam ptr_t AfRst  = (AF_DEFAULT > DEPTH) ? DepthP : ptr_t'(AF_DEFAULT);
    localparam ptr_t AeRst  = (AE_DEFAULT > DEPTH) ? DepthP : ptr_t'(AE_DEFAULT);

    function automatic ptr_t sat_depth(input ptr_t v);
        return (v > DepthP) ? DepthP : v;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t level_q, level_d;
    ptr_t af_thr_q, af_thr_d;
    ptr_t ae_thr_q, ae_thr_d;
    logic wr_full_q, wr_full_d;
    logic rd_empty_q, rd_empty_d;
    logic af_q, af_d;
    logic ae_q, ae_d;
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    logic wr_acc;
    logic rd_acc;

    // Acceptance looks only at registered flags, so a simultaneous pop never frees a slot
    // for a write in the same cycle (and vice versa); flush drops both requests.
    assign wr_acc = wr_en && !wr_full_q && !flush;
    assign rd_acc = rd_en && !rd_empty_q && !flush;

    always_comb begin
        af_thr_d = af_thr_q;
        ae_thr_d = ae_thr_q;
        if (thresh_ld) begin
            af_thr_d = sat_depth(af_thresh);
            ae_thr_d = sat_depth(ae_thresh);
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + ptr_t'(1);
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + ptr_t'(1);
                2'b01:   level_d = level_q - ptr_t'(1);
                default: level_d = level_q;
            endcase
        end

        // Flags are computed from next state so they are glitch-free registers that already
        // reflect this edge's accepts and any freshly loaded threshold.
        wr_full_d  = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                     (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
        rd_empty_d = (wr_ptr_d == rd_ptr_d);
        af_d       = (level_d >= af_thr_d);
        ae_d       = (level_d <= ae_thr_d);
        ovf_d      = wr_en && wr_full_q && !flush;
        udf_d      = rd_en && rd_empty_q && !flush;
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            af_thr_q   <= AfRst;
            ae_thr_q   <= AeRst;
            wr_full_q  <= 1'b0;
            rd_empty_q <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            af_thr_q   <= af_thr_d;
            ae_thr_q   <= ae_thr_d;
            wr_full_q  <= wr_full_d;
            rd_empty_q <= rd_empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Storage is not reset; flush and reset only move the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end

`ifdef LINE_FIFO_FWFT_EN
    // Head word is presented combinationally once the registered empty flag has dropped.
    assign rd_valid = !rd_empty_q;
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q[ADDR_WIDTH-1:0]] : '0;
`else
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        if (rd_acc) rd_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

    assign wr_full      = wr_full_q;
    assign rd_empty     = rd_empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign water_level  = level_q;

endmodule

// File: tb/tb_line_fifo_sync_param.sv
// tb_line_fifo_sync_param
//   Self-checking bench for line_fifo_sync_param (standard read build), 8-bit words,
//   default depth 2048. Inputs change 1 time unit after the rising edge; outputs are
//   checked there too.
module tb_line_fifo_sync_param;

    localparam int DW = 8;
    localparam int AW = 11;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          tb_rst;
    logic          flush;
    logic [AW:0]   af_thresh;
    logic [AW:0]   ae_thresh;
    logic          thresh_ld;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_full;
    logic          almost_full;
    logic          overflow;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_empty;
    logic          almost_empty;
    logic          underflow;
    logic [AW:0]   water_level;

    int n_checks = 0;
    int n_errors = 0;

    line_fifo_sync_param #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_DEFAULT(1020),
        .AE_DEFAULT(4)
    ) dut (
        .clk         (clk),
        .tb_rst      (tb_rst),
        .flush       (flush),
        .af_thresh   (af_thresh),
        .ae_thresh   (ae_thresh),
        .thresh_ld   (thresh_ld),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_full     (wr_full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_empty    (rd_empty),
        .almost_empty(almost_empty),
        .underflow   (underflow),
        .water_level (water_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [7:0]  wd;
        logic        rd;
        logic        fl;
        logic        ld;
        logic [11:0] af;
        logic [11:0] ae;
        int          lvl;
        logic        full;
        logic        empty;
        logic        afl;
        logic        ael;
        logic        ovf;
        logic        udf;
        logic        rv;
        logic [7:0]  rdat;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [7:0] wd, input logic rd,
                                input logic fl, input logic ld, input logic [11:0] af,
                                input logic [11:0] ae, input int lvl, input logic full,
                                input logic empty, input logic afl, input logic ael,
                                input logic ovf, input logic udf, input logic rv,
                                input logic [7:0] rdat);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.fl = fl; v.ld = ld; v.af = af; v.ae = ae;
        v.lvl = lvl; v.full = full; v.empty = empty; v.afl = afl; v.ael = ael;
        v.ovf = ovf; v.udf = udf; v.rv = rv; v.rdat = rdat;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int lvl, input logic full,
                             input logic empty, input logic afl, input logic ael,
                             input logic ovf, input logic udf);
        chk({tag, ".level"}, int'(water_level), lvl);
        chk({tag, ".full"}, int'(wr_full), int'(full));
        chk({tag, ".empty"}, int'(rd_empty), int'(empty));
        chk({tag, ".almost_full"}, int'(almost_full), int'(afl));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(ael));
        chk({tag, ".overflow"}, int'(overflow), int'(ovf));
        chk({tag, ".underflow"}, int'(underflow), int'(udf));
    endtask

    task automatic chk_rd(input string tag, input logic rv, input logic [7:0] rdat);
        chk({tag, ".rd_valid"}, int'(rd_valid), int'(rv));
        chk({tag, ".rd_data"}, int'(rd_data), int'(rdat));
    endtask

    // One clock with the given requests; returns 1 unit after the edge with inputs idle.
    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic f);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        flush     = 1'b0;
        thresh_ld = 1'b0;
    endtask

    task automatic load_thr(input logic [11:0] af, input logic [11:0] ae);
        thresh_ld = 1'b1;
        af_thresh = af;
        ae_thresh = ae;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    vec_t tbl [15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dv;
        int lvl;

        tb_rst = 1'b1; flush = 1'b0; thresh_ld = 1'b0; af_thresh = '0; ae_thresh = '0;
        wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;

        // Reset state while reset is held.
        #12;
        chk_state("reset", 0, 0, 1, 0, 1, 0, 0);
        chk_rd("reset", 0, 8'h00);
        @(posedge clk);
        #1;
        tb_rst = 1'b0;

        // Directed vectors from an empty FIFO with small thresholds.
        tbl[0]  = mk(0, 8'h00, 0, 0, 1, 12'd3,    12'd1,    0, 0, 1, 0, 1, 0, 0, 0, 8'h00);
        tbl[1]  = mk(1, 8'hA1, 0, 0, 0, 12'd0,    12'd0,    1, 0, 0, 0, 1, 0, 0, 0, 8'h00);
        tbl[2]  = mk(1, 8'hA2, 0, 0, 0, 12'd0,    12'd0,    2, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        tbl[3]  = mk(1, 8'hA3, 0, 0, 0, 12'd0,    12'd0,    3, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        tbl[4]  = mk(0, 8'h00, 1, 0, 0, 12'd0,    12'd0,    2, 0, 0, 0, 0, 0, 0, 1, 8'hA1);
        tbl[5]  = mk(1, 8'hA4, 1, 0, 0, 12'd0,    12'd0,    2, 0, 0, 0, 0, 0, 0, 1, 8'hA2);
        tbl[6]  = mk(0, 8'h00, 0, 0, 0, 12'd0,    12'd0,    2, 0, 0, 0, 0, 0, 0, 0, 8'hA2);
        tbl[7]  = mk(0, 8'h00, 0, 0, 1, 12'd4095, 12'd4095, 2, 0, 0, 0, 1, 0, 0, 0, 8'hA2);
        tbl[8]  = mk(0, 8'h00, 1, 0, 0, 12'd0,    12'd0,    1, 0, 0, 0, 1, 0, 0, 1, 8'hA3);
        tbl[9]  = mk(0, 8'h00, 1, 0, 0, 12'd0,    12'd0,    0, 0, 1, 0, 1, 0, 0, 1, 8'hA4);
        tbl[10] = mk(0, 8'h00, 1, 0, 0, 12'd0,    12'd0,    0, 0, 1, 0, 1, 0, 1, 0, 8'hA4);
        tbl[11] = mk(1, 8'hA5, 1, 0, 0, 12'd0,    12'd0,    1, 0, 0, 0, 1, 0, 1, 0, 8'hA4);
        tbl[12] = mk(1, 8'hA6, 1, 1, 0, 12'd0,    12'd0,    0, 0, 1, 0, 1, 0, 0, 0, 8'hA4);
        tbl[13] = mk(0, 8'h00, 0, 0, 0, 12'd0,    12'd0,    0, 0, 1, 0, 1, 0, 0, 0, 8'hA4);
        tbl[14] = mk(0, 8'h00, 0, 0, 1, 12'd1020, 12'd4,    0, 0, 1, 0, 1, 0, 0, 0, 8'hA4);

        for (int i = 0; i < 15; i++) begin
            thresh_ld = tbl[i].ld;
            af_thresh = tbl[i].af;
            ae_thresh = tbl[i].ae;
            drive(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].fl);
            chk_state($sformatf("v%0d", i), tbl[i].lvl, tbl[i].full, tbl[i].empty,
                      tbl[i].afl, tbl[i].ael, tbl[i].ovf, tbl[i].udf);
            chk_rd($sformatf("v%0d", i), tbl[i].rv, tbl[i].rdat);
        end

        // Fill to DEPTH with a down-counter pattern.
        for (int i = 0; i < DEPTH; i++) begin
            dv = 8'(DEPTH - 1 - i);
            drive(1'b1, dv, 1'b0, 1'b0);
            chk_state($sformatf("fill%0d", i), i + 1, (i + 1) == DEPTH, 1'b0,
                      (i + 1) >= 1020, (i + 1) <= 4, 1'b0, 1'b0);
        end

        // Write while full: overflow pulse only, level held.
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        chk_state("ovf", DEPTH, 1, 0, 1, 0, 1, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk_state("ovf_after", DEPTH, 1, 0, 1, 0, 0, 0);

        // Over-range af threshold saturates to DEPTH, so full still counts as almost full.
        load_thr(12'd4095, 12'd4);
        chk("af_sat.almost_full", int'(almost_full), 1);
        load_thr(12'd1020, 12'd4);

        // Both requests at full: only the pop is accepted.
        drive(1'b1, 8'h66, 1'b1, 1'b0);
        chk_state("full_both", DEPTH - 1, 0, 0, 1, 0, 1, 0);
        chk_rd("full_both", 1, 8'(DEPTH - 1));

        // Drain the rest in write order.
        for (int i = 1; i < DEPTH; i++) begin
            lvl = DEPTH - 1 - i;
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk_state($sformatf("drain%0d", i), lvl, 0, lvl == 0, lvl >= 1020, lvl <= 4, 0, 0);
            chk_rd($sformatf("drain%0d", i), 1, 8'(DEPTH - 1 - i));
        end

        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk_state("udf", 0, 0, 1, 0, 1, 0, 1);
        chk_rd("udf", 0, 8'h00);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk_state("udf_after", 0, 0, 1, 0, 1, 0, 0);

        // Simultaneous read/write at level 5 keeps the level and the order.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        chk("lvl5.level", int'(water_level), 5);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 8'(8'h15 + k), 1'b1, 1'b0);
            chk($sformatf("sim%0d.level", k), int'(water_level), 5);
            chk_rd($sformatf("sim%0d", k), 1, 8'(8'h10 + k));
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("sdrain%0d.level", k), int'(water_level), 4 - k);
            chk_rd($sformatf("sdrain%0d", k), 1, 8'(8'h1A + k));
        end

        // Flush at level 300.
        for (int i = 0; i < 300; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        chk("pre_flush.level", int'(water_level), 300);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk_state("flush", 0, 0, 1, 0, 1, 0, 0);
        chk("flush.rd_valid", int'(rd_valid), 0);
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk_rd("post_flush", 1, 8'h77);
        chk("post_flush.level", int'(water_level), 0);

        // Runtime thresholds af=16, ae=2.
        load_thr(12'd16, 12'd2);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            chk($sformatf("thr_w%0d.almost_full", i), int'(almost_full), int'((i + 1) >= 16));
        end
        for (int k = 0; k < 14; k++) begin
            lvl = 15 - k;
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("thr_r%0d.almost_empty", k), int'(almost_empty), int'(lvl <= 2));
            chk($sformatf("thr_r%0d.almost_full", k), int'(almost_full), int'(lvl >= 16));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("thr_end.empty", int'(rd_empty), 1);

        // Asynchronous reset in the middle of a read stream.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        chk_rd("pre_rst", 1, 8'h31);
        #2;
        tb_rst = 1'b1;
        #1;
        chk_state("mid_rst", 0, 0, 1, 0, 1, 0, 0);
        chk_rd("mid_rst", 0, 8'h00);
        rd_en = 1'b0;
        #2;
        tb_rst = 1'b0;
        @(posedge clk);
        #1;
        chk_state("post_rst", 0, 0, 1, 0, 1, 0, 0);
        // Default af threshold is back after reset: 3 writes stay well below it.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h00, 1'b0, 1'b0);
        chk("post_rst.almost_full", int'(almost_full), 0);
        chk("post_rst.almost_empty", int'(almost_empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
